user_input: RTL and testbench



---
 rtl/user_input.sv | 117 +++++++++++
 tb/tb_user_input.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/user_input.sv
// Level-to-pulse converter: input synchronizer, optional debounce filter and a
// two-state edge FSM emitting one registered clk-cycle pulse per accepted rise.
//
// state | meaning
// IDLE  | accepted level low (or not yet seen high); next rise fires a pulse
// HELD  | pulse already issued for the current high level; wait for a low
module user_input #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;
    logic                   acc;

    state_t state_q;
    state_t state_d;
    logic   out_q;
    logic   out_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign acc = s;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            // Accept on the N-th consecutive differing cycle, so compare against N-1
            // and never let the counter itself reach N.
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          acc_q;
            logic          acc_d;

            always_comb begin
                cnt_d = '0;
                acc_d = acc_q;
                if (s != acc_q) begin
                    if (cnt_q == LAST) begin
                        acc_d = s;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                    acc_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    acc_q <= acc_d;
                end
            end

            assign acc = acc_q;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        out_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    out_d   = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (!acc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_user_input.sv
// Bench for user_input: one instance without debounce and one with a 4-cycle
// debounce share the stimulus; a history-based model predicts both outputs.
module tb_user_input;

    localparam int SS = 2;
    localparam int N4 = 4;
    localparam int HN = 4096;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic in_r  = 1'b0;
    logic out0;
    logic out4;

    user_input #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(0)) dut0 (
        .clk  (clk),
        .reset(rst),
        .in   (in_r),
        .out  (out0)
    );

    user_input #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(N4)) dut4 (
        .clk  (clk),
        .reset(rst),
        .in   (in_r),
        .out  (out4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int gcyc  = 0;
    int q0[$];
    int q4[$];

    // Model: history of sampled inputs since reset; s is the input delayed by the
    // synchronizer depth, the debounced level flips once the previous N values of s
    // all disagree with it, and a pulse marks each rise of the accepted level.
    bit hist [0:HN-1];
    bit s_a  [0:HN-1];
    bit a4_a [0:HN-1];
    int e = 0;
    bit exp0 = 1'b0;
    bit exp4 = 1'b0;
    bit prev;
    bit flip;

    function automatic bit s_at(input int i);
        return (i >= 0) ? s_a[i] : 1'b0;
    endfunction

    function automatic bit a4_at(input int i);
        return (i >= 0) ? a4_a[i] : 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e    = 0;
            exp0 = 1'b0;
            exp4 = 1'b0;
        end else if (e < HN) begin
            hist[e] = in_r;
            s_a[e]  = (e - SS + 1 >= 0) ? hist[e-SS+1] : 1'b0;
            prev    = a4_at(e - 1);
            flip    = 1'b1;
            for (int j = 1; j <= N4; j++) begin
                if (s_at(e - j) == prev) flip = 1'b0;
            end
            a4_a[e] = flip ? ~prev : prev;
            exp0    = s_at(e - 1) & ~s_at(e - 2);
            exp4    = a4_at(e - 1) & ~a4_at(e - 2);
            e++;
        end
    end

    always @(posedge clk) gcyc++;

    always @(negedge clk) begin
        if (out0) q0.push_back(gcyc - 1);
        if (out4) q4.push_back(gcyc - 1);
        total += 2;
        if (out0 !== exp0) begin
            bad++;
            $display("FAIL cmp_out0 t=%0t got=%b want=%b", $time, out0, exp0);
        end
        if (out4 !== exp4) begin
            bad++;
            $display("FAIL cmp_out4 t=%0t got=%b want=%b", $time, out4, exp4);
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic drive(input bit lvl, input int n);
        in_r = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        q0.delete();
        q4.delete();
    endtask

    int k;

    initial begin
        // Reset held with input high, then release: counts as a fresh press.
        in_r = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_out0", int'(out0), 0);
            chk("reset_out4", int'(out4), 0);
        end
        rst = 1'b0;
        k = gcyc;
        clear_q();
        drive(1'b1, 10);
        drive(1'b0, 12);
        chk("rel_n0_count", q0.size(), 1);
        if (q0.size() > 0) chk("rel_n0_edge", q0[0], k + 2);
        chk("rel_n4_count", q4.size(), 1);
        if (q4.size() > 0) chk("rel_n4_edge", q4[0], k + 6);

        // Single press held 20 cycles.
        clear_q();
        k = gcyc;
        drive(1'b1, 20);
        drive(1'b0, 12);
        chk("press_n0_count", q0.size(), 1);
        if (q0.size() > 0) chk("press_n0_edge", q0[0], k + 2);
        chk("press_n4_count", q4.size(), 1);
        if (q4.size() > 0) chk("press_n4_edge", q4[0], k + 6);

        // Divided-clock square wave, period 16.
        clear_q();
        k = gcyc;
        repeat (10) begin
            drive(1'b1, 8);
            drive(1'b0, 8);
        end
        drive(1'b0, 12);
        chk("sq_n0_count", q0.size(), 10);
        chk("sq_n4_count", q4.size(), 10);
        if (q0.size() == 10) begin
            chk("sq_n0_first", q0[0], k + 2);
            for (int i = 1; i < 10; i++) chk("sq_n0_gap", q0[i] - q0[i-1], 16);
        end
        if (q4.size() == 10) chk("sq_n4_first", q4[0], k + 6);

        // Release and re-press with a one-cycle low.
        clear_q();
        k = gcyc;
        drive(1'b1, 5);
        drive(1'b0, 1);
        drive(1'b1, 5);
        drive(1'b0, 12);
        chk("repress_n0_count", q0.size(), 2);
        if (q0.size() == 2) begin
            chk("repress_n0_first", q0[0], k + 2);
            chk("repress_n0_gap", q0[1] - q0[0], 6);
        end
        chk("repress_n4_count", q4.size(), 1);

        // Three-cycle glitch, then a ten-cycle level.
        clear_q();
        k = gcyc;
        drive(1'b1, 3);
        drive(1'b0, 12);
        chk("glitch_n4_count", q4.size(), 0);
        chk("glitch_n0_count", q0.size(), 1);
        clear_q();
        k = gcyc;
        drive(1'b1, 10);
        drive(1'b0, 12);
        chk("lvl10_n4_count", q4.size(), 1);
        if (q4.size() > 0) chk("lvl10_n4_edge", q4[0], k + 6);

        // Input toggling every cycle.
        clear_q();
        k = gcyc;
        repeat (10) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        drive(1'b0, 12);
        chk("tog_n0_count", q0.size(), 10);
        if (q0.size() == 10) begin
            for (int i = 0; i < 10; i++) chk("tog_n0_edge", q0[i], k + 2 + 2 * i);
        end
        chk("tog_n4_count", q4.size(), 0);

        // Asynchronous reset while the pulse is high, input kept high.
        k = gcyc;
        in_r = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("prerst_out0", int'(out0), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out0", int'(out0), 0);
        chk("async_rst_out4", int'(out4), 0);
        repeat (3) begin
            @(negedge clk);
            chk("hold_rst_out0", int'(out0), 0);
            chk("hold_rst_out4", int'(out4), 0);
        end
        rst = 1'b0;
        clear_q();
        k = gcyc;
        drive(1'b1, 12);
        drive(1'b0, 12);
        chk("midrst_n0_count", q0.size(), 1);
        if (q0.size() > 0) chk("midrst_n0_edge", q0[0], k + 2);
        chk("midrst_n4_count", q4.size(), 1);
        if (q4.size() > 0) chk("midrst_n4_edge", q4[0], k + 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
